reorder_buffer: RTL and testbench

In-order commit stage placed directly downstream of the result queue; it consumes `complete_info` messages (49-bit `Result`). It allocates one entry per dispatched instruction, marks entries done as results arrive out of order, and retires them in program order to the register file. A committed entry flagged mispredicted raises a one-cycle `flash` to the whole back end.

---
 rtl/reorder_buffer.sv | 139 +++++++++++++
 tb/tb_reorder_buffer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order commit stage for out-of-order completions.
// Entries are allocated at the tail, marked done as results arrive with
// their tags, and retired one per cycle from the head. A retiring entry
// flagged mispredicted raises a one-cycle flash and empties the buffer.
// Optional build macro: ROB_COMMIT_BYPASS_EN lets a completion that hits
// the waiting head entry retire straight from the message in the same edge.
module reorder_buffer #(
    parameter int DEPTH = 32,
    localparam int TW = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          alloc_en,
    input  logic [5:0]    alloc_dest,
    input  logic          alloc_dest_en,
    output logic [TW-1:0] alloc_tag,
    output logic          alloc_full,
    input  logic          complete_info_en,
    input  logic [48:0]   complete_info_msg,
    output logic          complete_info_reject,
    output logic          commit_en,
    output logic [TW-1:0] commit_tag,
    output logic [5:0]    commit_dest,
    output logic [31:0]   commit_data,
    output logic          commit_wr,
    output logic          flash,
    output logic [5:0]    count
);
    localparam logic [TW:0] FULL = (TW+1)'(DEPTH);

    // Pointers carry a wrap bit so full (diff == DEPTH) and empty differ.
    logic [TW:0]       head_q, tail_q;
    logic [DEPTH-1:0]  valid_q, done_q, mis_q, den_q;
    logic [5:0]        dest_q [DEPTH];
    logic [31:0]       data_q [DEPTH];

    logic              flash_q, cen_q, cwr_q;
    logic [TW-1:0]     ctag_q;
    logic [5:0]        cdest_q;
    logic [31:0]       cdata_q;

    logic [TW:0]       occ;
    logic [TW-1:0]     hidx, tidx, cmp_tag;
    logic              cmp_acc, cmp_hit, do_alloc, bypass, do_commit;
    logic              mark_done, c_mis, do_flush;
    logic [31:0]       c_data;
    logic              unused_msg;

    assign hidx      = head_q[TW-1:0];
    assign tidx      = tail_q[TW-1:0];
    assign occ       = tail_q - head_q;
    assign count     = 6'(occ);
    assign alloc_full = (occ == FULL);
    assign alloc_tag = tidx;

    // Completions are refused only while the flush pulse is up.
    assign complete_info_reject = flash_q;
    assign cmp_acc   = complete_info_en & ~flash_q;
    assign cmp_tag   = complete_info_msg[44 +: TW];
    assign cmp_hit   = cmp_acc & valid_q[cmp_tag] & ~done_q[cmp_tag];
    assign do_alloc  = alloc_en & ~alloc_full & ~flash_q;
    assign unused_msg = ^complete_info_msg[48:32];

`ifdef ROB_COMMIT_BYPASS_EN
    // A hit on the undone head entry retires directly from the message.
    assign bypass    = cmp_hit & (cmp_tag == hidx);
`else
    assign bypass    = 1'b0;
`endif

    // Bypass requires the head to be not done, so the two sources are exclusive.
    assign do_commit = (~flash_q & valid_q[hidx] & done_q[hidx]) | bypass;
    assign mark_done = cmp_hit & ~bypass;
    assign c_mis     = bypass ? complete_info_msg[43]   : mis_q[hidx];
    assign c_data    = bypass ? complete_info_msg[31:0] : data_q[hidx];
    assign do_flush  = do_commit & c_mis;

    // Pointers, valid/done bits and the registered commit/flash outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            done_q  <= '0;
            flash_q <= 1'b0;
            cen_q   <= 1'b0;
            cwr_q   <= 1'b0;
            ctag_q  <= '0;
            cdest_q <= '0;
            cdata_q <= '0;
        end else begin
            cen_q   <= do_commit;
            cwr_q   <= do_commit & den_q[hidx];
            flash_q <= do_flush;
            if (do_commit) begin
                ctag_q  <= hidx;
                cdest_q <= dest_q[hidx];
                cdata_q <= c_data;
            end
            if (do_flush) begin
                head_q  <= '0;
                tail_q  <= '0;
                valid_q <= '0;
                done_q  <= '0;
            end else begin
                if (do_alloc) begin
                    tail_q        <= tail_q + 1'b1;
                    valid_q[tidx] <= 1'b1;
                    done_q[tidx]  <= 1'b0;
                end
                if (mark_done) done_q[cmp_tag] <= 1'b1;
                if (do_commit) begin
                    head_q        <= head_q + 1'b1;
                    valid_q[hidx] <= 1'b0;
                    done_q[hidx]  <= 1'b0;
                end
            end
        end
    end

    // Entry payload; only meaningful while the matching valid bit is set.
    always_ff @(posedge clock) begin
        if (do_alloc) begin
            dest_q[tidx] <= alloc_dest;
            den_q[tidx]  <= alloc_dest_en;
        end
        if (mark_done) begin
            data_q[cmp_tag] <= complete_info_msg[31:0];
            mis_q[cmp_tag]  <= complete_info_msg[43];
        end
    end

    assign commit_en   = cen_q;
    assign commit_wr   = cwr_q;
    assign commit_tag  = ctag_q;
    assign commit_dest = cdest_q;
    assign commit_data = cdata_q;
    assign flash       = flash_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios followed by
// random traffic, all compared against a program-order queue model.
module tb_reorder_buffer;
    localparam int DEPTH = 32;
    localparam int TW = $clog2(DEPTH);

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          alloc_en = 1'b0;
    logic [5:0]    alloc_dest = '0;
    logic          alloc_dest_en = 1'b0;
    logic [TW-1:0] alloc_tag;
    logic          alloc_full;
    logic          complete_info_en = 1'b0;
    logic [48:0]   complete_info_msg = '0;
    logic          complete_info_reject;
    logic          commit_en;
    logic [TW-1:0] commit_tag;
    logic [5:0]    commit_dest;
    logic [31:0]   commit_data;
    logic          commit_wr;
    logic          flash;
    logic [5:0]    count;

    reorder_buffer #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n),
        .alloc_en(alloc_en), .alloc_dest(alloc_dest), .alloc_dest_en(alloc_dest_en),
        .alloc_tag(alloc_tag), .alloc_full(alloc_full),
        .complete_info_en(complete_info_en), .complete_info_msg(complete_info_msg),
        .complete_info_reject(complete_info_reject),
        .commit_en(commit_en), .commit_tag(commit_tag), .commit_dest(commit_dest),
        .commit_data(commit_data), .commit_wr(commit_wr),
        .flash(flash), .count(count)
    );

    always #5 clock = ~clock;

    // Reference model: live instructions in program order.
    typedef struct {
        int          tag;
        logic [5:0]  dest;
        bit          de;
        bit          done;
        bit          mis;
        logic [31:0] data;
    } ent_t;

    ent_t        rob[$];
    int          ntag;
    bit          m_flash, m_cen, m_cwr;
    int          m_ctag;
    logic [5:0]  m_cdest;
    logic [31:0] m_cdata;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    endtask

    task automatic model_reset();
        rob.delete();
        ntag = 0; m_flash = 0; m_cen = 0; m_cwr = 0;
        m_ctag = 0; m_cdest = '0; m_cdata = '0;
    endtask

    task automatic model_edge(input bit ae, input logic [5:0] ad, input bit ade,
                              input bit ce, input logic [48:0] msg);
        bit   c = 0;
        ent_t ret;
        int   sz0 = rob.size();
        int   t = int'(msg[48:44]) % DEPTH;
        ent_t ne;
        if (!m_flash && sz0 > 0 && rob[0].done) begin c = 1; ret = rob[0]; end
        if (ce && !m_flash) begin
            for (int k = 0; k < sz0; k++) begin
                if (rob[k].tag == t && !rob[k].done) begin
`ifdef ROB_COMMIT_BYPASS_EN
                    if (k == 0) begin
                        c = 1; ret = rob[0];
                        ret.data = msg[31:0]; ret.mis = msg[43];
                    end else begin
                        rob[k].done = 1; rob[k].data = msg[31:0]; rob[k].mis = msg[43];
                    end
`else
                    rob[k].done = 1; rob[k].data = msg[31:0]; rob[k].mis = msg[43];
`endif
                end
            end
        end
        if (c) void'(rob.pop_front());
        if (ae && sz0 < DEPTH && !m_flash) begin
            ne.tag = ntag; ne.dest = ad; ne.de = ade; ne.done = 0; ne.mis = 0; ne.data = '0;
            rob.push_back(ne);
            ntag = (ntag + 1) % DEPTH;
        end
        m_flash = c && ret.mis;
        if (m_flash) begin rob.delete(); ntag = 0; end
        m_cen = c;
        m_cwr = c && ret.de;
        if (c) begin m_ctag = ret.tag; m_cdest = ret.dest; m_cdata = ret.data; end
    endtask

    task automatic check_all();
        chk("count", 32'(count), rob.size());
        chk("alloc_full", 32'(alloc_full), 32'(rob.size() == DEPTH));
        if (rob.size() < DEPTH) chk("alloc_tag", 32'(alloc_tag), ntag);
        chk("flash", 32'(flash), 32'(m_flash));
        chk("reject", 32'(complete_info_reject), 32'(m_flash));
        chk("commit_en", 32'(commit_en), 32'(m_cen));
        chk("commit_wr", 32'(commit_wr), 32'(m_cwr));
        chk("commit_tag", 32'(commit_tag), m_ctag);
        chk("commit_dest", 32'(commit_dest), 32'(m_cdest));
        chk("commit_data", commit_data, m_cdata);
    endtask

    task automatic step(input bit ae, input logic [5:0] ad, input bit ade,
                        input bit ce, input logic [48:0] msg);
        alloc_en = ae; alloc_dest = ad; alloc_dest_en = ade;
        complete_info_en = ce; complete_info_msg = msg;
        @(posedge clock);
        model_edge(ae, ad, ade, ce, msg);
        #1;
        check_all();
    endtask

    function automatic logic [48:0] mk(input int tag, input bit mis, input logic [31:0] data);
        logic [4:0] t5 = 5'(tag);
        return {t5, mis, 11'h0, data};
    endfunction

    task automatic idle();                 step(0, 6'd0, 0, 0, '0); endtask
    task automatic alloc(input int d);     step(1, 6'(d), 1, 0, '0); endtask
    task automatic comp(input int t, input bit m, input logic [31:0] d);
        step(0, 6'd0, 0, 1, mk(t, m, d));
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 0;
        alloc_en = 0; complete_info_en = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1;
        model_reset();
        check_all();
    endtask

    initial begin
        model_reset();
        do_reset();

        // In-order retirement of out-of-order completions.
        alloc(1); alloc(2); alloc(3);
        comp(2, 0, 32'hA); comp(0, 0, 32'hB); comp(1, 0, 32'hC);
        repeat (4) idle();

        // Mispredict flush: tags 2,3 never commit, completion during flash rejected.
        do_reset();
        for (int i = 0; i < 4; i++) alloc(10 + i);
        comp(1, 1, 32'h1111); comp(0, 0, 32'h2222);
        idle(); idle();
        chk("flash_pulse", 32'(flash), 32'd1);
        comp(2, 0, 32'h3333);
        chk("flash_drop", 32'(flash), 32'd0);
        chk("count_after_flash", 32'(count), 32'd0);
        repeat (3) idle();

        // Fill to DEPTH, extra alloc ignored, one commit frees a slot at tag 0.
        for (int i = 0; i < DEPTH; i++) alloc(i);
        chk("full_count", 32'(count), 32'(DEPTH));
        alloc(63);
        comp(0, 0, 32'h55);
        idle(); idle();
        chk("wrap_tag", 32'(alloc_tag), 32'd0);
        alloc(7);
        repeat (2) idle();

        // Unallocated tag and duplicate completion.
        do_reset();
        alloc(4); alloc(5);
        comp(5, 0, 32'hDEAD);
        comp(1, 0, 32'h11); comp(1, 0, 32'h22);
        comp(0, 0, 32'h33);
        repeat (4) idle();

        // Completion-to-commit latency on a single entry.
        do_reset();
        alloc(9);
        comp(0, 0, 32'h77);
`ifdef ROB_COMMIT_BYPASS_EN
        chk("lat_e", 32'(commit_en), 32'd1);
`else
        chk("lat_e", 32'(commit_en), 32'd0);
        idle();
        chk("lat_e1", 32'(commit_en), 32'd1);
`endif
        idle(); idle();

        // Asynchronous reset with live entries.
        for (int i = 0; i < 10; i++) alloc(i);
        comp(0, 0, 32'h99);
        idle();
        #3 reset_n = 0;
        #1;
        chk("ar_count", 32'(count), 32'd0);
        chk("ar_full", 32'(alloc_full), 32'd0);
        chk("ar_tag", 32'(alloc_tag), 32'd0);
        chk("ar_cen", 32'(commit_en), 32'd0);
        chk("ar_cwr", 32'(commit_wr), 32'd0);
        chk("ar_ctag", 32'(commit_tag), 32'd0);
        chk("ar_cdata", commit_data, 32'd0);
        chk("ar_flash", 32'(flash), 32'd0);
        chk("ar_reject", 32'(complete_info_reject), 32'd0);
        model_reset();
        @(negedge clock);
        reset_n = 1;

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            bit          ae = ($urandom % 10) < 6;
            bit          ce = ($urandom % 10) < 7;
            int          t;
            logic [48:0] m;
            if (rob.size() > 0 && ($urandom % 4) != 0) t = rob[$urandom % rob.size()].tag;
            else t = $urandom % DEPTH;
            m = mk(t, ($urandom % 20) == 0, $urandom);
            m[42:32] = 11'($urandom);
            step(ae, 6'($urandom), 1'($urandom), ce, m);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
